// File: rtl/r_ordering_unit_if.sv
// R-channel valid/ready bundle shared by the
// ordering unit and its neighbours.
interface r_if #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport sender (
    output valid, id, data, resp, last,
    input  ready
  );

  modport receiver (
    input  valid, id, data, resp, last,
    output ready
  );
endinterface

// File: rtl/r_ordering_unit.sv
// Read-response reorder buffer: stores tagged R beats
// per slot and releases whole bursts in AR order.
module r_ordering_unit #(
  parameter  int ID_WIDTH   = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int RESP_WIDTH = 2,
  parameter  int NUM_TAGS   = 4,
  parameter  int MAX_BEATS  = 4,
  localparam int TAG_W      = $clog2(NUM_TAGS),
  localparam int CNT_W      = $clog2(NUM_TAGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_orig_id,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  r_if.receiver               r_in,
  r_if.sender                 r_out,
  output logic [CNT_W-1:0]    outstanding,
  output logic                proto_err
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int IDX_W  = (MAX_BEATS > 1) ?
                          $clog2(MAX_BEATS) : 1;

  logic [NUM_TAGS-1:0]              busy_q, busy_d;
  logic [NUM_TAGS-1:0]              ls_q, ls_d;
  logic [NUM_TAGS-1:0][ID_WIDTH-1:0] oid_q, oid_d;
  logic [NUM_TAGS-1:0][BEAT_W-1:0]  wr_q, wr_d;
  logic [NUM_TAGS-1:0][BEAT_W-1:0]  rd_q, rd_d;
  logic [TAG_W-1:0]                 head_q, head_d;
  logic [TAG_W-1:0]                 tail_q, tail_d;
  logic [CNT_W-1:0]                 out_q, out_d;
  logic                             err_q, err_d;

  logic [DATA_WIDTH-1:0] data_q [NUM_TAGS][MAX_BEATS];
  logic [RESP_WIDTH-1:0] resp_q [NUM_TAGS][MAX_BEATS];
  logic                  last_q [NUM_TAGS][MAX_BEATS];

  logic [TAG_W-1:0] wtag;
  logic [IDX_W-1:0] widx, ridx;
  logic             wr_ok, wr_err;
  logic             head_valid, pop, pop_last;
  logic             alloc_fire;

  assign r_in.ready  = 1'b1;
  assign wtag        = r_in.id[TAG_W-1:0];
  assign widx        = wr_q[wtag][IDX_W-1:0];
  assign ridx        = rd_q[head_q][IDX_W-1:0];

  assign wr_ok  = r_in.valid & busy_q[wtag] & ~ls_q[wtag] &
                  (wr_q[wtag] != BEAT_W'(MAX_BEATS));
  assign wr_err = r_in.valid & ~wr_ok;

  assign head_valid = busy_q[head_q] &
                      (rd_q[head_q] < wr_q[head_q]);
  assign pop        = head_valid & r_out.ready;
  assign pop_last   = pop & last_q[head_q][ridx];

  assign alloc_ready = ~busy_q[tail_q];
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_tag   = tail_q;
  assign outstanding = out_q;
  assign proto_err   = err_q;

  always_comb begin
    busy_d = busy_q;
    ls_d   = ls_q;
    oid_d  = oid_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (wr_ok) begin
      wr_d[wtag] = wr_q[wtag] + 1'b1;
      if (r_in.last) ls_d[wtag] = 1'b1;
    end
    if (pop) begin
      rd_d[head_q] = rd_q[head_q] + 1'b1;
      if (pop_last) busy_d[head_q] = 1'b0;
    end
    // alloc slot is never busy, so it cannot collide
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      ls_d[tail_q]   = 1'b0;
      oid_d[tail_q]  = alloc_orig_id;
      wr_d[tail_q]   = '0;
      rd_d[tail_q]   = '0;
    end
    head_d = head_q + TAG_W'(pop_last);
    tail_d = tail_q + TAG_W'(alloc_fire);
    out_d  = out_q + CNT_W'(alloc_fire)
                   - CNT_W'(pop_last);
    err_d  = err_q | wr_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      ls_q   <= '0;
      oid_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ls_q   <= ls_d;
      oid_q  <= oid_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      tail_q <= tail_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_q[wtag][widx] <= r_in.data;
      resp_q[wtag][widx] <= r_in.resp;
      last_q[wtag][widx] <= r_in.last;
    end
  end

  always_comb begin
    r_out.valid = head_valid;
    r_out.id    = '0;
    r_out.data  = '0;
    r_out.resp  = '0;
    r_out.last  = 1'b0;
    if (head_valid) begin
      r_out.id   = oid_q[head_q];
      r_out.data = data_q[head_q][ridx];
      r_out.resp = resp_q[head_q][ridx];
      r_out.last = last_q[head_q][ridx];
    end
  end

endmodule

// File: tb/tb_r_ordering_unit.sv
// Bench for r_ordering_unit: directed scenarios plus
// random traffic against a queue-based reference.
module tb_r_ordering_unit;

  localparam int NT = 4;
  localparam int MB = 4;

  typedef struct packed {
    logic        last;
    logic [1:0]  resp;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [31:0] alloc_orig_id = '0;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic [2:0]  outstanding;
  logic        proto_err;

  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) in_if ();
  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) out_if ();

  r_ordering_unit #(
    .ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2),
    .NUM_TAGS(NT), .MAX_BEATS(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_orig_id(alloc_orig_id),
    .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .r_in(in_if),
    .r_out(out_if),
    .outstanding(outstanding),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference: allocation-order queue + per-tag beat queues
  int          ord[$];
  beat_t       bq[NT][$];
  logic [31:0] oid[NT];
  bit          busy[NT];
  bit          lseen[NT];
  int          wcnt[NT];
  int          tlen[NT];
  int          nalloc;
  bit          err;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void model_clear();
    ord.delete();
    for (int i = 0; i < NT; i++) begin
      bq[i].delete();
      busy[i] = 0; lseen[i] = 0;
      wcnt[i] = 0; oid[i] = '0; tlen[i] = 1;
    end
    nalloc = 0;
    err = 0;
  endfunction

  function automatic beat_t mk(input logic [63:0] d,
                               input logic [1:0] r,
                               input logic l);
    beat_t b;
    b.data = d; b.resp = r; b.last = l;
    return b;
  endfunction

  task automatic cycle(input logic av, input logic [31:0] aid,
                       input logic bv, input logic [31:0] bid,
                       input beat_t b, input logic ordy);
    bit    ev, aok, bok;
    int    h, t, tt;
    beat_t eb;
    ev = (ord.size() > 0) && (bq[ord[0]].size() > 0);
    h  = (ord.size() > 0) ? ord[0] : 0;
    eb = ev ? bq[h][0] : '0;
    chk("alloc_ready", alloc_ready, ord.size() < NT);
    chk("alloc_tag", alloc_tag, nalloc % NT);
    chk("outstanding", outstanding, ord.size());
    chk("proto_err", proto_err, err);
    chk("r_valid", out_if.valid, ev);
    chk("r_id", out_if.id, ev ? oid[h] : 32'h0);
    chk("r_data", out_if.data, eb.data);
    chk("r_resp", out_if.resp, eb.resp);
    chk("r_last", out_if.last, eb.last);
    alloc_valid   = av;
    alloc_orig_id = aid;
    in_if.valid   = bv;
    in_if.id      = bid;
    in_if.data    = b.data;
    in_if.resp    = b.resp;
    in_if.last    = b.last;
    out_if.ready  = ordy;
    t   = int'(bid[1:0]);
    aok = av && (ord.size() < NT);
    bok = bv && busy[t] && !lseen[t] && (wcnt[t] < MB);
    if (bv && !bok) err = 1;
    if (ev && ordy) begin
      void'(bq[h].pop_front());
      if (eb.last) begin
        busy[h] = 0;
        void'(ord.pop_front());
      end
    end
    if (bok) begin
      bq[t].push_back(b);
      wcnt[t]++;
      if (b.last) lseen[t] = 1;
    end
    if (aok) begin
      tt = nalloc % NT;
      busy[tt] = 1; lseen[tt] = 0; wcnt[tt] = 0;
      oid[tt] = aid;
      bq[tt].delete();
      ord.push_back(tt);
      nalloc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, '0, ordy);
  endtask

  task automatic alloc(input logic [31:0] aid);
    cycle(1, aid, 0, 0, '0, 1);
  endtask

  task automatic beat(input int t, input logic [63:0] d,
                      input logic l, input logic ordy);
    cycle(0, 0, 1, 32'(t) | 32'hABC0_0000, mk(d, 2'(t), l), ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 0; in_if.valid = 0; out_if.ready = 0;
    #1;
    model_clear();
    chk("rst_valid", out_if.valid, 1'b0);
    chk("rst_outst", outstanding, 3'd0);
    chk("rst_err", proto_err, 1'b0);
    chk("rst_tag", alloc_tag, 2'd0);
    chk("rst_ready", alloc_ready, 1'b1);
    chk("rst_in_ready", in_if.ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_traffic(input int n);
    int t;
    logic av, bv, last;
    for (int c = 0; c < n; c++) begin
      av = ($urandom_range(0, 1) == 1);
      if (av && ord.size() < NT)
        tlen[nalloc % NT] = $urandom_range(1, MB);
      t  = $urandom_range(0, NT - 1);
      bv = busy[t] && !lseen[t] && ($urandom_range(0, 9) < 6);
      last = (wcnt[t] + 1 == tlen[t]);
      cycle(av, $urandom, bv,
            ($urandom & 32'hFFFF_FFFC) | 32'(t),
            mk({$urandom, $urandom}, 2'($urandom), last),
            $urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    in_if.valid = 0; in_if.id = '0; in_if.data = '0;
    in_if.resp = '0; in_if.last = 0; out_if.ready = 0;
    model_clear();
    #2;
    do_reset();

    // single in-order read
    alloc(32'h5);
    beat(0, 64'hD0, 0, 1);
    beat(0, 64'hD1, 1, 1);
    idle(3, 1);
    chk("head_moved", dut.head_q, 2'd1);

    // reversed completion
    do_reset();
    alloc(32'hA);
    alloc(32'hB);
    beat(1, 64'h10, 0, 1);
    beat(1, 64'h11, 0, 1);
    beat(1, 64'h12, 1, 1);
    beat(0, 64'h00, 1, 1);
    idle(6, 1);

    // interleaved beats
    do_reset();
    alloc(32'h21);
    alloc(32'h22);
    for (int i = 0; i < 3; i++) begin
      beat(0, 64'(i), i == 2, 1);
      beat(1, 64'(100 + i), i == 2, 1);
    end
    idle(6, 1);

    // full, refused alloc in freeing cycle, then grant
    do_reset();
    for (int i = 0; i < NT; i++) alloc(32'h30 + 32'(i));
    cycle(1, 32'h99, 1, 32'h0, mk(64'hF0, 2'd0, 1), 0);
    cycle(1, 32'h99, 0, 0, '0, 1);
    cycle(1, 32'h9A, 0, 0, '0, 1);
    idle(2, 1);

    // backpressure with pending head data
    do_reset();
    alloc(32'h77);
    beat(0, 64'hB0, 0, 0);
    beat(0, 64'hB1, 1, 0);
    idle(5, 0);
    idle(4, 1);

    // protocol errors: unallocated tag, then 5th beat
    do_reset();
    beat(2, 64'hEE, 1, 1);
    alloc(32'h44);
    for (int i = 0; i < MB + 1; i++)
      beat(0, 64'(i), 0, 0);
    idle(2, 1);
    chk("err_sticky", proto_err, 1'b1);

    // reset mid-burst
    alloc(32'h55);
    beat(1, 64'h5A, 0, 0);
    do_reset();
    idle(2, 1);

    // random traffic exercising wrap and interleave
    do_reset();
    rand_traffic(1500);
    idle(40, 1);
    chk("wrapped", nalloc > 10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
